// File: rtl/ascon_aead128_pkg.sv
// ascon_aead128_pkg: shared Ascon state type, round primitives and permutation-controller constants
// ascon_state packs x0..x4 with x0 in the most significant 64 bits.
package ascon_aead128_pkg;
  typedef logic [0:4][63:0] ascon_state;
  localparam int ROUNDS_P12 = 12;
  localparam int ROUNDS_P8 = 8;
  localparam logic [3:0] RND_START_P12 = 4'h4;
  localparam logic [3:0] RND_START_P8 = 4'h8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} perm_fsm_t;
  function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned n);
    return 64'({x, x} >> n);
  endfunction
  // Round value 4..F maps to the p^12 constant index 0..11: {~j, j} with j = rnd-4.
  function automatic ascon_state const_add(input ascon_state s, input logic [3:0] rnd);
    ascon_state r;
    logic [3:0] j;
    j = rnd - 4'h4;
    r = s;
    r[2][7:0] = s[2][7:0] ^ {4'hF - j, j};
    return r;
  endfunction
  function automatic ascon_state ps(input ascon_state s);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = s[0] ^ s[4];
    x1 = s[1];
    x2 = s[2] ^ s[1];
    x3 = s[3];
    x4 = s[4] ^ s[3];
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    return {x0, x1, x2, x3, x4};
  endfunction
  function automatic ascon_state pl(input ascon_state s);
    ascon_state r;
    r[0] = s[0] ^ ror(s[0], 19) ^ ror(s[0], 28);
    r[1] = s[1] ^ ror(s[1], 61) ^ ror(s[1], 39);
    r[2] = s[2] ^ ror(s[2], 1) ^ ror(s[2], 6);
    r[3] = s[3] ^ ror(s[3], 10) ^ ror(s[3], 17);
    r[4] = s[4] ^ ror(s[4], 7) ^ ror(s[4], 41);
    return r;
  endfunction
  function automatic ascon_state round(input ascon_state s, input logic [3:0] rnd);
    return pl(ps(const_add(s, rnd)));
  endfunction
endpackage

// File: rtl/ascon_round.sv
// ascon_round: one combinational Ascon round (pc, ps, pl) on a 320-bit state
// Ports: rnd = round value 4..F, s_in = state before, s_out = state after.
module ascon_round
  import ascon_aead128_pkg::*;
(
  input  logic [3:0] rnd,
  input  ascon_state s_in,
  output ascon_state s_out
);
  ascon_state s_pc, s_ps;
  assign s_pc = const_add(s_in, rnd);
  assign s_ps = ps(s_pc);
  assign s_out = pl(s_ps);
endmodule

// File: rtl/ascon_perm_ctrl.sv
// ascon_perm_ctrl: sequences Ascon p^12 / p^8 over a 320-bit state, ROUNDS_PER_CYCLE rounds per clock
// Ports: in_valid/in_ready/in_p12/in_state = request handshake; out_valid/out_ready/out_state = result
// handshake; busy = RUN or DONE; rnd_cur = round value of the first unrolled round (0 outside RUN).
// Optional ASCON_PERM_BUSY_CNT_EN adds busy_cycles, a saturating count of busy clocks.
module ascon_perm_ctrl
  import ascon_aead128_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_p12,
  input  logic [319:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [319:0] out_state,
  output logic         busy,
`ifdef ASCON_PERM_BUSY_CNT_EN
  output logic [31:0]  busy_cycles,
`endif
  output logic [3:0]   rnd_cur
);
  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4) begin : g_bad_rpc
    $error("ROUNDS_PER_CYCLE must be 1, 2 or 4");
  end
  localparam logic [3:0] RSTEP = 4'(ROUNDS_PER_CYCLE);
  perm_fsm_t fsm_q, fsm_d;
  ascon_state st_q, st_d;
  logic [3:0] rnd_q, rnd_d;
  ascon_state chain [ROUNDS_PER_CYCLE+1];
  assign chain[0] = st_q;
  for (genvar k = 0; k < ROUNDS_PER_CYCLE; k++) begin : g_rnd
    ascon_round u_round (.rnd(rnd_q + 4'(k)), .s_in(chain[k]), .s_out(chain[k+1]));
  end
  // Round values end at F for both p^12 and p^8, so the RUN phase ends when rnd wraps to 0.
  always_comb begin
    fsm_d = fsm_q;
    st_d = st_q;
    rnd_d = rnd_q;
    case (fsm_q)
      IDLE: if (in_valid) begin
        st_d = in_state;
        rnd_d = in_p12 ? RND_START_P12 : RND_START_P8;
        fsm_d = RUN;
      end
      RUN: begin
        st_d = chain[ROUNDS_PER_CYCLE];
        rnd_d = rnd_q + RSTEP;
        fsm_d = (rnd_d == 4'h0) ? DONE : RUN;
      end
      DONE: fsm_d = out_ready ? IDLE : DONE;
      default: fsm_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= IDLE;
      st_q <= '0;
      rnd_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      st_q <= st_d;
      rnd_q <= rnd_d;
    end
  end
  assign in_ready = fsm_q == IDLE;
  assign out_valid = fsm_q == DONE;
  assign busy = fsm_q != IDLE;
  assign out_state = st_q;
  assign rnd_cur = (fsm_q == RUN) ? rnd_q : 4'h0;
`ifdef ASCON_PERM_BUSY_CNT_EN
  logic [31:0] busy_cycles_q, busy_cycles_d;
  assign busy_cycles_d = (busy && busy_cycles_q != '1) ? busy_cycles_q + 32'd1 : busy_cycles_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_cycles_q <= '0;
    else busy_cycles_q <= busy_cycles_d;
  end
  assign busy_cycles = busy_cycles_q;
`endif
endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// tb_ascon_perm_ctrl: scoreboard bench for ascon_perm_ctrl at ROUNDS_PER_CYCLE 1 and 4
module tb_ascon_perm_ctrl;
  localparam int RS [2] = '{1, 4};
  localparam logic [4:0] SBOX [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                                       5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                                       5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                                       5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam int RA [5] = '{19, 61, 1, 10, 7};
  localparam int RB [5] = '{28, 39, 6, 17, 41};
  localparam logic [319:0] V5 = {64'h1, 64'h2, 64'h3, 64'h4, 64'h5};
  localparam logic [319:0] RV = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h55aa33cc0ff0f00f,
                                 64'hdeadbeefcafef00d, 64'h8badf00d13579bdf};
  localparam logic [319:0] RV2 = {64'h243f6a8885a308d3, 64'h13198a2e03707344, 64'ha4093822299f31d0,
                                  64'h082efa98ec4e6c89, 64'h452821e638d01377};
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic iv [2], ir [2], p12 [2], ov [2], ordy [2], bsy [2];
  logic [319:0] ist [2], ost [2];
  logic [3:0] rc [2];
`ifdef ASCON_PERM_BUSY_CNT_EN
  logic [31:0] bc [2];
`endif
  typedef struct {
    int d;
    logic [319:0] st;
    int lat;
  } exp_t;
  exp_t sb [$];
  int vectors = 0;
  int fails = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  ascon_perm_ctrl #(.ROUNDS_PER_CYCLE(1)) u_r1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_p12(p12[0]),
    .in_state(ist[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_state(ost[0]), .busy(bsy[0]),
`ifdef ASCON_PERM_BUSY_CNT_EN
    .busy_cycles(bc[0]),
`endif
    .rnd_cur(rc[0])
  );
  ascon_perm_ctrl #(.ROUNDS_PER_CYCLE(4)) u_r4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_p12(p12[1]),
    .in_state(ist[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_state(ost[1]), .busy(bsy[1]),
`ifdef ASCON_PERM_BUSY_CNT_EN
    .busy_cycles(bc[1]),
`endif
    .rnd_cur(rc[1])
  );
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction
  // Reference permutation: table S-box per bit column, rounds 12-nr..11 of p^12.
  function automatic logic [319:0] model(input logic [319:0] s, input int nr);
    logic [63:0] x [5];
    logic [4:0] v;
    for (int i = 0; i < 5; i++) x[i] = s[319-64*i -: 64];
    for (int j = 12 - nr; j < 12; j++) begin
      x[2][7:0] = x[2][7:0] ^ 8'((15 - j) * 16 + j);
      for (int b = 0; b < 64; b++) begin
        v = SBOX[{x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]}];
        x[0][b] = v[4];
        x[1][b] = v[3];
        x[2][b] = v[2];
        x[3][b] = v[1];
        x[4][b] = v[0];
      end
      for (int i = 0; i < 5; i++) x[i] = x[i] ^ rotr(x[i], RA[i]) ^ rotr(x[i], RB[i]);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction
  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  function automatic int find(input int d);
    foreach (sb[i]) if (sb[i].d == d) return i;
    return -1;
  endfunction
  task automatic monitor();
    int acc [2];
    int k;
    logic [3:0] er [2];
    logic [319:0] pst [2];
    logic pv [2], pr [2], hs [2];
    for (int d = 0; d < 2; d++) begin
      acc[d] = 0;
      er[d] = 4'h0;
      pst[d] = '0;
      pv[d] = 1'b0;
      pr[d] = 1'b0;
      hs[d] = 1'b0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
        if (rst_n) begin
          if (hs[d]) begin
            chk("idle_after_out", {318'b0, ir[d], ov[d]}, 320'b10);
            hs[d] = 1'b0;
          end
          if (bsy[d] && !ov[d]) begin
            chk("rnd_cur_run", {315'b0, ir[d], rc[d]}, {316'b0, er[d]});
            er[d] = er[d] + 4'(RS[d]);
          end
          if (!bsy[d]) chk("rnd_cur_idle", 320'(rc[d]), 320'b0);
          if (ov[d]) begin
            k = find(d);
            chk("in_ready_in_done", 320'(ir[d]), 320'b0);
            if (k < 0) chk("out_without_request", 320'(ov[d]), 320'b0);
            else begin
              if (!pv[d]) chk("latency", 320'(cyc - acc[d] - 1), 320'(sb[k].lat));
              else if (!pr[d]) chk("hold_state", ost[d], pst[d]);
              if (ordy[d]) begin
                chk("out_state", ost[d], sb[k].st);
                sb.delete(k);
                hs[d] = 1'b1;
              end
            end
          end
          if (iv[d] && ir[d]) begin
            acc[d] = cyc;
            er[d] = p12[d] ? 4'h4 : 4'h8;
          end
        end
        pv[d] = rst_n && ov[d];
        pr[d] = ordy[d];
        pst[d] = ost[d];
      end
    end
  endtask
  task automatic issue(input int d, input logic [319:0] s, input bit p);
    exp_t e;
    int t;
    t = 0;
    iv[d] = 1'b1;
    ist[d] = s;
    p12[d] = p;
    e.d = d;
    e.st = model(s, p ? 12 : 8);
    e.lat = (p ? 12 : 8) / RS[d];
    sb.push_back(e);
    @(negedge clk);
    while (!ir[d] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ir[d]) chk("accept_timeout", 320'(ir[d]), 320'b1);
    @(posedge clk);
    #1 iv[d] = 1'b0;
  endtask
  task automatic wait_idle(input int d);
    int t;
    t = 0;
    @(negedge clk);
    while ((!ir[d] || bsy[d]) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!ir[d] || bsy[d]) chk("idle_timeout", 320'(bsy[d]), 320'b0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    int t;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0;
      p12[d] = 1'b0;
      ist[d] = '0;
      ordy[d] = 1'b1;
    end
    fork
      monitor();
    join_none
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready", 320'(ir[d]), 320'b1);
      chk("rst_out_valid", 320'(ov[d]), 320'b0);
      chk("rst_busy", 320'(bsy[d]), 320'b0);
      chk("rst_rnd_cur", 320'(rc[d]), 320'b0);
      chk("rst_out_state", ost[d], 320'b0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
`ifdef ASCON_PERM_BUSY_CNT_EN
    chk("busy_cycles_rst", 320'(bc[0]), 320'b0);
    issue(0, '0, 1'b1);
    issue(0, RV, 1'b1);
    wait_idle(0);
    chk("busy_cycles", 320'(bc[0]), 320'd26);
    chk("busy_cycles_idle_dut", 320'(bc[1]), 320'd0);
`endif
    issue(0, '0, 1'b1);
    issue(0, V5, 1'b0);
    issue(1, RV, 1'b1);
    issue(1, RV, 1'b0);
    issue(0, RV, 1'b1);
    issue(0, RV, 1'b0);
    wait_idle(0);
    wait_idle(1);
    ordy[0] = 1'b0;
    issue(0, RV2, 1'b1);
    t = 0;
    while (!ov[0] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!ov[0]) chk("done_timeout", 320'(ov[0]), 320'b1);
    @(posedge clk);
    #1;
    repeat (5) begin
      iv[0] = ~iv[0];
      ist[0] = ~ist[0];
      @(posedge clk);
      #1;
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    wait_idle(0);
    issue(0, RV, 1'b1);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrun_rst_out_valid", 320'(ov[0]), 320'b0);
    chk("midrun_rst_in_ready", 320'(ir[0]), 320'b1);
    chk("midrun_rst_busy", 320'(bsy[0]), 320'b0);
    chk("midrun_rst_rnd_cur", 320'(rc[0]), 320'b0);
    chk("midrun_rst_out_state", ost[0], 320'b0);
    #1 rst_n = 1'b1;
    for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].d == 0) sb.delete(i);
    @(posedge clk);
    #1;
    issue(0, V5, 1'b0);
    wait_idle(0);
    chk("scoreboard_empty", 320'(sb.size()), 320'b0);
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
